if_id_queue: RTL and testbench

//   Two-entry instruction queue between the fetch stage (PC register + instruction memory) and decode.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/if_id_queue.sv | 90 +++++++++
 tb/tb_if_id_queue.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline-register types and constants for the IF/ID and later stage registers.
package pipeline_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0: the canonical bubble presented to decode.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// Two-entry IF/ID instruction queue; push->validD latency 1 cycle, outputs from registered state only.
// Backpressure: readyF drops when full (no path from readyD); flushD drops everything queued.
module if_id_queue
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  validF,
    input  logic [DATA_WIDTH-1:0] instrF,
    input  logic [DATA_WIDTH-1:0] pcF,
    input  logic [DATA_WIDTH-1:0] pc_plus4F,
    output logic                  readyF,
    input  logic                  flushD,
    input  logic                  readyD,
    output logic                  validD,
    output logic [DATA_WIDTH-1:0] instrD,
    output logic [DATA_WIDTH-1:0] pcD,
    output logic [DATA_WIDTH-1:0] pc_plus4D,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    // Entry fields come from the shared package type, so DATA_WIDTH must equal XLEN.
    if_id_entry_t entry_q [2];

    logic [1:0]           count_q, count_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic         push;
    logic         pop;
    if_id_entry_t head;

    assign readyF = (count_q != 2'd2);
    assign validD = (count_q != 2'd0);
    assign head   = entry_q[rd_ptr_q];

    assign instrD    = validD ? head.instr    : NOP_INSTR;
    assign pcD       = validD ? head.pc       : '0;
    assign pc_plus4D = validD ? head.pc_plus4 : '0;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        push        = validF && readyF && !flushD;
        pop         = validD && readyD && !flushD;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        stall_cnt_d = stall_cnt_q;

        if (flushD) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            if (push && !pop)      count_d = count_q + 2'd1;
            else if (pop && !push) count_d = count_q - 2'd1;
        end

        if (validF && !readyF && !flushD && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Payload is masked by validD, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[wr_ptr_q] <= '{instr: instrF, pc: pcF, pc_plus4: pc_plus4F};
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomised and directed bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        validF;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] pc_plus4F;
    logic        readyF;
    logic        flushD;
    logic        readyD;
    logic        validD;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pc_plus4D;
    logic [15:0] stall_cnt;

    if_id_queue #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .validF    (validF),
        .instrF    (instrF),
        .pcF       (pcF),
        .pc_plus4F (pc_plus4F),
        .readyF    (readyF),
        .flushD    (flushD),
        .readyD    (readyD),
        .validD    (validD),
        .instrD    (instrD),
        .pcD       (pcD),
        .pc_plus4D (pc_plus4D),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_stall;
    int          checks;
    int          failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic mv;
        mv = (mq.size() != 0);
        chk("validD", {31'd0, validD}, {31'd0, mv});
        chk("readyF", {31'd0, readyF}, {31'd0, (mq.size() != 2)});
        chk("instrD", instrD, mv ? mq[0].instr : NOP);
        chk("pcD", pcD, mv ? mq[0].pc : 32'd0);
        chk("pc_plus4D", pc_plus4D, mv ? mq[0].pc4 : 32'd0);
        chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
    endtask

    // Drive one cycle of inputs, check the current state, then advance the model.
    task automatic step(input logic vf, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic rd);
        logic m_rdy, m_push, m_pop;
        ent_t e;
        @(negedge clk);
        validF    = vf;
        instrF    = ins;
        pcF       = pc;
        pc_plus4F = pc + 32'd4;
        flushD    = fl;
        readyD    = rd;
        #1;
        check_outputs();
        m_rdy  = (mq.size() < 2);
        m_push = vf && m_rdy;
        m_pop  = (mq.size() != 0) && rd;
        if (vf && !m_rdy && !fl && m_stall < 32'hFFFF) m_stall++;
        if (fl) begin
            mq.delete();
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                e.instr = ins;
                e.pc    = pc;
                e.pc4   = pc + 32'd4;
                mq.push_back(e);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_stall   = 0;
        rst_n     = 1'b0;
        validF    = 1'b0;
        instrF    = '0;
        pcF       = '0;
        pc_plus4F = '0;
        flushD    = 1'b0;
        readyD    = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_validD", {31'd0, validD}, 32'd0);
        chk("rst_instrD", instrD, NOP);
        chk("rst_readyF", {31'd0, readyF}, 32'd1);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming with decode always ready
        step(1'b1, 32'hA000_0001, 32'h100, 1'b0, 1'b1);
        step(1'b1, 32'hA000_0002, 32'h104, 1'b0, 1'b1);
        step(1'b1, 32'hA000_0003, 32'h108, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Back-pressure: two pushes fill the queue, four stalled cycles follow
        step(1'b1, 32'hB000_0000, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'hB000_0001, 32'h204, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'hB000_0002, 32'h208, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("bp_stall4", {16'd0, stall_cnt}, 32'd4);
        chk("bp_head", pcD, 32'h200);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle();

        // Full with simultaneous pop: the push waits a cycle
        step(1'b1, 32'hC000_0000, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'hC000_0001, 32'h304, 1'b0, 1'b0);
        step(1'b1, 32'hC000_0002, 32'h308, 1'b0, 1'b1);
        step(1'b1, 32'hC000_0002, 32'h308, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle();

        // Flush while full with push and pop asserted
        step(1'b1, 32'hD000_0000, 32'h500, 1'b0, 1'b0);
        step(1'b1, 32'hD000_0001, 32'h504, 1'b0, 1'b0);
        step(1'b1, 32'hD000_0002, 32'h508, 1'b1, 1'b1);
        step(1'b1, 32'hE000_0000, 32'h400, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("flush_first", pcD, 32'h400);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            rpc = {$urandom_range(0, 32'h3FFF), 2'b00};
            step(($urandom_range(0, 9) < 7), $urandom(), rpc,
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1));
        end

        // Asynchronous reset between edges while full
        step(1'b1, 32'hF000_0000, 32'h600, 1'b0, 1'b0);
        step(1'b1, 32'hF000_0001, 32'h604, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_arst_validD", {31'd0, validD}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_validD", {31'd0, validD}, 32'd0);
        chk("arst_readyF", {31'd0, readyF}, 32'd1);
        chk("arst_instrD", instrD, NOP);
        chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
        mq.delete();
        m_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: hold a stall until the counter pins at all-ones
        step(1'b1, 32'h1111_0000, 32'h700, 1'b0, 1'b0);
        step(1'b1, 32'h1111_0001, 32'h704, 1'b0, 1'b0);
        for (int i = 0; i < 65534; i++) step(1'b1, 32'h1111_0002, 32'h708, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("sat_fffe", {16'd0, stall_cnt}, 32'h0000_FFFE);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h1111_0002, 32'h708, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("sat_ffff", {16'd0, stall_cnt}, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
